// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: hands each DRAM memory slot to one requester
// (video, refresh, DMA, blitter or CPU). Slots alternate between phase A
// (video/refresh side) and phase B (DMA/blitter/CPU side). The grant is a
// registered one-hot {ref,cpu,blt,dma,vid}; ack pulses the outgoing grant
// for one cycle at the start of the following slot.
//
// Optional feature: define ARB_REFRESH_EN to build the refresh counter and
// the ref_pending/ref_overdue flags. Without it, refresh is never granted
// and both flags are tied low.
module mem_slot_arbiter #(
  parameter int REFRESH_PERIOD = 64,
  parameter int CPU_STARVE_MAX = 3
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       slot_start,
  input  logic       turbo,
  input  logic       vid_req,
  input  logic       dma_req,
  input  logic       blt_req,
  input  logic       cpu_req,
  output logic [4:0] gnt,
  output logic [4:0] ack,
  output logic       phase,
  output logic       ref_pending,
  output logic       ref_overdue
);

  localparam int G_VID = 0;
  localparam int G_DMA = 1;
  localparam int G_BLT = 2;
  localparam int G_CPU = 3;
  localparam int G_REF = 4;

  localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_MAX);

  // Reject parameter values the counters cannot represent.
  if (REFRESH_PERIOD < 2) begin : g_bad_refresh_period
    $error("REFRESH_PERIOD must be at least 2");
  end
  if (CPU_STARVE_MAX < 1 || CPU_STARVE_MAX > 15) begin : g_bad_starve_max
    $error("CPU_STARVE_MAX must be in 1..15");
  end

  logic       new_phase;
  logic [4:0] b_pick;
  logic [4:0] gnt_next;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;

  // Grant and starvation decision for the slot that starts at this edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    new_phase   = ~phase;
    b_pick      = '0;
    gnt_next    = '0;
    starve_next = starve_cnt;

    if (ref_overdue)                           b_pick[G_REF] = 1'b1;
    else if (cpu_req && starve_cnt == STARVE_MAX) b_pick[G_CPU] = 1'b1;
    else if (dma_req)                          b_pick[G_DMA] = 1'b1;
    else if (blt_req)                          b_pick[G_BLT] = 1'b1;
    else if (cpu_req)                          b_pick[G_CPU] = 1'b1;

    if (!new_phase) begin
      if (vid_req)          gnt_next[G_VID] = 1'b1;
      else if (ref_pending) gnt_next[G_REF] = 1'b1;
      else if (turbo)       gnt_next        = b_pick;
    end else begin
      gnt_next = b_pick;
    end

    if (gnt_next[G_CPU] || !cpu_req)         starve_next = '0;
    else if (new_phase && starve_cnt < STARVE_MAX) starve_next = starve_cnt + 4'd1;
  end

  // Slot state: phase, grant, one-cycle ack and CPU starvation count.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      phase      <= 1'b1;
      gnt        <= '0;
      ack        <= '0;
      starve_cnt <= '0;
    end else if (slot_start) begin
      // NOTE: non-blocking assignments so ack captures the outgoing gnt
      // while gnt takes its new value on the same edge.
      phase      <= new_phase;
      ack        <= gnt;
      gnt        <= gnt_next;
      starve_cnt <= starve_next;
    end else begin
      ack <= '0;
    end
  end

`ifdef ARB_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_PERIOD);

  logic [RCW-1:0] ref_cnt;
  logic           ref_wrap;

  assign ref_wrap = (ref_cnt == RCW'(REFRESH_PERIOD - 1));

  // Refresh bookkeeping: one request per period, at most one owed.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_overdue <= 1'b0;
    end else if (slot_start) begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (gnt_next[G_REF]) begin
        // The grant consumes the old request; a coinciding wrap owes a new one.
        ref_pending <= ref_wrap;
        ref_overdue <= 1'b0;
      end else if (ref_wrap) begin
        ref_pending <= 1'b1;
        ref_overdue <= ref_overdue | ref_pending;
      end
    end
  end
`else
  assign ref_pending = 1'b0;
  assign ref_overdue = 1'b0;
`endif

endmodule
